muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide engine producing the {hi, lo} HILO write-back pair.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              div_zero_q, div_zero_d;

  // Operand magnitudes; signed ops (MULT/DIV) have op[0] clear.
  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

  // One shift-add / restoring-divide step. rem_q holds the upper product half during multiply
  // and the partial remainder during divide; quo_q holds the multiplier or dividend/quotient.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_sub;
  logic           div_ge;

  assign mul_sum   = rem_q + (quo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift - {1'b0, opnd_q};

  // Sign fix applied on the FIX edge.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {rem_q[WIDTH-1:0], quo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -quo_q : quo_q;
  assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  logic [2*WIDTH-1:0] fast_prod;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
  localparam bit FastMul = 1'b0;
  assign fast_prod = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    opnd_d     = opnd_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d   = StCalc;
          busy_d    = 1'b1;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_rem_d = signed_op & src_a[WIDTH-1];
          dz_d      = op[1] & (src_b == '0);
          opnd_d    = mag_b;
          quo_d     = mag_a;
          rem_d     = '0;
          if (FastMul && !op[1]) begin
            state_d = StFix;
            rem_d   = {1'b0, fast_prod[2*WIDTH-1:WIDTH]};
            quo_d   = fast_prod[WIDTH-1:0];
          end
        end
      end

      StCalc: begin
        if (flush) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            rem_d = div_ge ? div_sub : div_shift;
            quo_d = {quo_q[WIDTH-2:0], div_ge};
          end else begin
            rem_d = {1'b0, mul_sum[WIDTH:1]};
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end
        end
      end

      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d     = 1'b1;
          div_zero_d = dz_q;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = dz_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      opnd_q     <= opnd_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed HILO vectors, randomized ops against an
// arithmetic reference model, flush, asynchronous reset and back-to-back issue.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  localparam int ND = 11;
  logic [1:0]  d_op [ND] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2};
  logic [31:0] d_a  [ND] = '{32'hffffffff, 32'hfffffffd, 32'h80000000, 32'hfffffff9, 32'h7,
                             32'h80000000, 32'h1234, 32'h3, 32'hfffffff0, 32'h64, 32'h7};
  logic [31:0] d_b  [ND] = '{32'hffffffff, 32'h7, 32'h80000000, 32'h2, 32'h2,
                             32'hffffffff, 32'h0, 32'h5, 32'h0, 32'h7, 32'hfffffffe};
  logic [31:0] d_hi [ND] = '{32'hfffffffe, 32'hffffffff, 32'h40000000, 32'hffffffff, 32'h1,
                             32'h0, 32'h1234, 32'h0, 32'hfffffff0, 32'h2, 32'h1};
  logic [31:0] d_lo [ND] = '{32'h1, 32'hffffffeb, 32'h0, 32'hfffffffd, 32'h3,
                             32'h80000000, 32'hffffffff, 32'hf, 32'hffffffff, 32'he, 32'hfffffffd};
  logic        d_dz [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  // Reference result {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        p = 64'(sa * sb);
        model = {1'b0, p};
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        model = {1'b0, p};
      end
      default: begin
        if (b == 32'd0) begin
          model = {1'b1, a, 32'hffffffff};
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          model = {1'b0, r[31:0], q[31:0]};
        end else begin
          model = {1'b0, a % b, a / b};
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return (!o[1] && FastMul) ? 1 : 33;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/dz=%b expected 000", {busy, done, div_zero});
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    int cyc;
    for (int i = 0; i < ND; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_busy_rise: got %b expected 1", i, busy);
      end
      wait_done(cyc);
      checks++;
      if (cyc != exp_lat(d_op[i])) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, exp_lat(d_op[i]));
      end
      checks++;
      if ({div_zero, hi, lo} !== {d_dz[i], d_hi[i], d_lo[i]}) begin
        errors++;
        $display("FAIL dir%0d_result: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                 i, div_zero, hi, lo, d_dz[i], d_hi[i], d_lo[i]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy_done: got %b expected 0", i, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    int          cyc;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [64:0] exp;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hffffffff;
        3:       begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      exp = model(o, a, b);
      issue(o, a, b);
      wait_done(cyc);
      checks++;
      if (cyc != exp_lat(o) || {div_zero, hi, lo} !== exp) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got lat=%0d dz=%b hi=%h lo=%h expected lat=%0d %h",
                 i, o, a, b, cyc, div_zero, hi, lo, exp_lat(o), exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_flush();
    int cyc;
    bit saw_done;
    issue(2'd1, 32'd6, 32'd7);
    wait_done(cyc);
    @(negedge clk);
    issue(2'd2, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL flush_busy: got busy/done=%b expected 00", {busy, done});
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL flush_no_done: got done pulse expected none");
    end
    checks++;
    if ({div_zero, hi, lo} !== {1'b0, 32'd0, 32'd42}) begin
      errors++;
      $display("FAIL flush_keep: got dz=%b hi=%h lo=%h expected dz=0 hi=0 lo=2a",
               div_zero, hi, lo);
    end
    // flush beats start in the same idle cycle
    op    = 2'd1;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_same: got busy=%b expected 0", busy);
    end
    // start held high while busy with changing operands must not be taken
    op    = 2'd3;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      op    = 2'($urandom_range(0, 3));
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != 13 || {hi, lo} !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL start_ignored: got lat=%0d hi=%h lo=%h expected lat=13 hi=2 lo=e",
               cyc, hi, lo);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    issue(2'd3, 32'd5, 32'd0);
    wait_done(cyc);
    checks++;
    if ({div_zero, hi, lo} !== {1'b1, 32'd5, 32'hffffffff}) begin
      errors++;
      $display("FAIL divzero_pre: got dz=%b hi=%h lo=%h expected dz=1 hi=5 lo=ffffffff",
               div_zero, hi, lo);
    end
    @(negedge clk);
    issue(2'd2, 32'hfffffff9, 32'd2);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || {hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0",
               busy, done, div_zero, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL async_discard: got busy=%b expected 0", busy);
    end
    issue(2'd0, 32'hfffffffd, 32'd7);
    wait_done(cyc);
    checks++;
    if (cyc != exp_lat(2'd0) || {div_zero, hi, lo} !== {1'b0, 32'hffffffff, 32'hffffffeb}) begin
      errors++;
      $display("FAIL post_reset_op: got lat=%0d dz=%b hi=%h lo=%h expected lat=%0d hi=ffffffff lo=ffffffeb",
               cyc, div_zero, hi, lo, exp_lat(2'd0));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    issue(2'd1, 32'hffffffff, 32'hffffffff);
    wait_done(cyc);
    checks++;
    if ({hi, lo} !== {32'hfffffffe, 32'h1}) begin
      errors++;
      $display("FAIL b2b_first: got hi=%h lo=%h expected fffffffe/1", hi, lo);
    end
    issue(2'd2, 32'hfffffff9, 32'd2);
    wait_done(cyc);
    checks++;
    if (cyc != 33 || {hi, lo} !== {32'hffffffff, 32'hfffffffd}) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h expected lat=33 ffffffff/fffffffd",
               cyc, hi, lo);
    end
    issue(2'd3, 32'd7, 32'd2);
    wait_done(cyc);
    checks++;
    if (cyc != 33 || {div_zero, hi, lo} !== {1'b0, 32'd1, 32'd3}) begin
      errors++;
      $display("FAIL b2b_third: got lat=%0d dz=%b hi=%h lo=%h expected lat=33 dz=0 1/3",
               cyc, div_zero, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
